grid_row_serializer: RTL and testbench
======================================

Name: grid_row_serializer

Overview:
- Reader/transmitter for the 8x8 Game-of-Life grid produced by the evolve datapath (`data`).
- Snapshots a 64-bit grid on request, then streams it one 8-bit row per beat over a valid/ready handshake. Consumers are the LED-matrix scanner and the debug/UART path.
- Row r occupies grid bits [8r+7:8r]; row 0 = bits [7:0], sent first.

Parameters:
- ROWS, 8, rows per frame; row_idx width = $clog2(ROWS).
- COLS, 8, bits per row; grid width = ROWS*COLS.
- GAP_CYCLES, 0, idle cycles inserted between accepted rows, range 0..15.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- grid_in  in  64  grid to transmit, typically Grid_Evolved.
- grid_load  in  1  request to snapshot grid_in and start a frame.
- row_ready  in  1  consumer accepts the current row.
- row_valid  out  1  row_data/row_idx are valid.
- row_data  out  8  current row, bits [8r+7:8r] of the snapshot.
- row_idx  out  3  index of current row, 0..7.
- frame_done  out  1  one-cycle pulse after the last row is accepted.
- busy  out  1  frame in progress; grid_load is not accepted.
- load_dropped  out  1  one-cycle pulse when grid_load arrives while busy.
- live_count  out  7  population of the last frame; present only with GRID_POPCOUNT_EN.

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE; row_valid, busy, frame_done, load_dropped = 0; row_data, row_idx, snapshot, live_count = 0. Takes effect from any state, including mid-frame. A partially sent frame is discarded; no frame_done.
- States:
  - IDLE: busy=0, row_valid=0. grid_load=1 → snapshot <= grid_in, row_idx <= 0, go to SEND. row_valid=1 with row 0 on the next cycle (1-cycle latency).
  - SEND: row_valid=1, busy=1. row_data/row_idx are held stable while row_ready=0.
    - Handshake (row_valid && row_ready) with row_idx<ROWS-1: row_idx++. Go to GAP if GAP_CYCLES>0 (row_valid=0 for exactly GAP_CYCLES cycles), else stay in SEND with the next row on the following cycle. Back-to-back beats at 1 row/cycle are allowed.
    - Handshake on row_idx==ROWS-1: go to IDLE; frame_done=1 for exactly the next cycle; busy=0 from that cycle.
  - GAP: counter loads GAP_CYCLES-1 and decrements to 0, then returns to SEND.
- Snapshot is frozen during a frame; grid_in changes have no effect until the next accepted grid_load.
- grid_load while busy=1: ignored; load_dropped pulses one cycle. This includes the cycle of the final handshake, because busy is still 1 then.
- grid_load in the same cycle frame_done is high is accepted: busy=0 in that cycle.
- row_ready while row_valid=0 has no effect.
- row_idx wraps to 0 only via a new frame, never by increment past ROWS-1.

Optional Feature:
- Macro: GRID_POPCOUNT_EN.
- Defined:
  - live_count port exists. The accumulator clears at frame start and adds popcount(row_data) on each handshake.
  - live_count updates to the frame total in the same cycle frame_done asserts, and holds until the next frame completes or reset.
  - An aborted (reset) frame leaves live_count = 0.
- Undefined: no live_count port, no accumulator or popcount logic.

Decomposition:
- Package grid_pkg:
  - constants GRID_ROWS=8, GRID_COLS=8, GRID_W=64;
  - typedefs row_t (logic [7:0]) and grid_t (logic [63:0]);
  - enum ser_state_t {IDLE, SEND, GAP}.
- Sub-module: row_popcount (8-bit in, 4-bit count, combinational), instantiated only under GRID_POPCOUNT_EN.

Test Plan:
- Basic frame: grid_in=64'h0412_6424_0034_3C28, grid_load pulse, row_ready=1 always → rows 28,3C,34,00,24,64,12,04 with idx 0..7 on 8 consecutive cycles starting 1 cycle after load; frame_done one cycle after idx 7; live_count=17 (macro on).
- Backpressure: same grid, row_ready low for 3 cycles on row 2 → row_data=8'h34, row_idx=2 held for 4 cycles, no skipped or duplicated rows.
- Gap: GAP_CYCLES=2, row_ready=1 → row_valid pattern 1,0,0,1,0,0,...; 8 beats total; frame_done after the 8th beat.
- Overlap: grid_load during row 4 and during the final handshake → both ignored, load_dropped pulses twice, snapshot unchanged. grid_load in the frame_done cycle → new frame starts.
- Mid-frame reset: reset=0 during row 5 → next edge row_valid=0, busy=0, row_idx=0, no frame_done, live_count=0. After release, a new grid_load of 64'hFFFF_FFFF_FFFF_FFFF → 8 rows of FF, live_count=64.
- Snapshot isolation: change grid_in to 0 after load → transmitted rows still match the loaded grid.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared constants, types and FSM encoding for the grid row serializer.
package grid_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;
  localparam int GRID_W    = GRID_ROWS * GRID_COLS;

  typedef logic [GRID_COLS-1:0] row_t;
  typedef logic [GRID_W-1:0]    grid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/grid_row_popcount.sv
// Combinational population count of one 8-bit grid row.
module row_popcount
  import grid_pkg::*;
(
  input  row_t       row,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < GRID_COLS; i++) begin
      count = count + 4'(row[i]);
    end
  end

endmodule

// File: rtl/grid_row_serializer.sv
// Snapshots an 8x8 grid and streams it one row per valid/ready beat.
// Optional live-cell accumulator is enabled with GRID_POPCOUNT_EN.
module grid_row_serializer
  import grid_pkg::*;
#(
  parameter int ROWS       = GRID_ROWS,
  parameter int COLS       = GRID_COLS,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROWS*COLS-1:0]     grid_in,
  input  logic                     grid_load,
  input  logic                     row_ready,
  output logic                     row_valid,
  output logic [COLS-1:0]          row_data,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     load_dropped,
  output ser_state_t               state_dbg
`ifdef GRID_POPCOUNT_EN
  ,
  output logic [$clog2(ROWS*COLS+1)-1:0] live_count
`endif
);

  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  // Handshake: a row transfers on any rising edge where row_valid && row_ready.
  // While row_valid is high and row_ready low, row_data/row_idx stay stable.
  ser_state_t                     state, next_state;
  logic [ROWS-1:0][COLS-1:0]      snapshot;
  logic [3:0]                     gap_cnt;
  logic                           hs;
  logic                           last_row;
  logic                           start;

  assign row_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign row_data  = snapshot[row_idx];
  assign hs        = row_valid && row_ready;
  assign last_row  = (row_idx == ($clog2(ROWS))'(ROWS - 1));
  assign start     = (state == IDLE) && grid_load;
  assign state_dbg = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (grid_load) next_state = SEND;
      SEND: begin
        if (hs) begin
          if (last_row)            next_state = IDLE;
          else if (GAP_CYCLES > 0) next_state = GAP;
          else                     next_state = SEND;
        end
      end
      GAP:  if (gap_cnt == 4'd0) next_state = SEND;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      snapshot     <= '0;
      row_idx      <= '0;
      gap_cnt      <= '0;
      frame_done   <= 1'b0;
      load_dropped <= 1'b0;
    end else begin
      state        <= next_state;
      frame_done   <= hs && last_row;
      load_dropped <= grid_load && busy;
      if (start) begin
        snapshot <= grid_in;
        row_idx  <= '0;
      end
      if (hs && !last_row) begin
        row_idx <= row_idx + 1'b1;
        gap_cnt <= 4'(GAP_LOAD);
      end else if (state == GAP && gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

`ifdef GRID_POPCOUNT_EN
  logic [3:0]                         row_pop;
  logic [$clog2(ROWS*COLS+1)-1:0]     live_acc;

  row_popcount u_row_popcount (
    .row   (row_data),
    .count (row_pop)
  );

  // live_count only moves on frame completion, so an aborted frame never shows a partial total.
  always_ff @(posedge clk) begin
    if (!reset) begin
      live_acc   <= '0;
      live_count <= '0;
    end else begin
      if (start) begin
        live_acc <= '0;
      end else if (hs) begin
        live_acc <= live_acc + ($clog2(ROWS*COLS+1))'(row_pop);
      end
      if (hs && last_row) begin
        live_count <= live_acc + ($clog2(ROWS*COLS+1))'(row_pop);
      end
    end
  end
`endif

endmodule

// File: tb/tb_grid_row_serializer.sv
// Bench for grid_row_serializer: two instances (no gap, gap of 2) driven with shared
// directed and random stimulus, checked against a frame-level model.
module tb_grid_row_serializer;
  import grid_pkg::*;

  localparam int GAP_B = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     = 1'b0;
  logic [63:0] grid_in   = '0;
  logic        grid_load = 1'b0;
  logic        row_ready = 1'b0;

  logic [1:0]       row_valid, frame_done, busy, load_dropped;
  logic [1:0][7:0]  row_data;
  logic [1:0][2:0]  row_idx;
  ser_state_t       state_dbg [2];
`ifdef GRID_POPCOUNT_EN
  logic [1:0][6:0]  live_count;
`endif

  grid_row_serializer #(.GAP_CYCLES(0)) u_dut (
    .clk (clk), .reset (reset), .grid_in (grid_in), .grid_load (grid_load),
    .row_ready (row_ready), .row_valid (row_valid[0]), .row_data (row_data[0]),
    .row_idx (row_idx[0]), .frame_done (frame_done[0]), .busy (busy[0]),
    .load_dropped (load_dropped[0]), .state_dbg (state_dbg[0])
`ifdef GRID_POPCOUNT_EN
    , .live_count (live_count[0])
`endif
  );

  grid_row_serializer #(.GAP_CYCLES(GAP_B)) u_gap (
    .clk (clk), .reset (reset), .grid_in (grid_in), .grid_load (grid_load),
    .row_ready (row_ready), .row_valid (row_valid[1]), .row_data (row_data[1]),
    .row_idx (row_idx[1]), .frame_done (frame_done[1]), .busy (busy[1]),
    .load_dropped (load_dropped[1]), .state_dbg (state_dbg[1])
`ifdef GRID_POPCOUNT_EN
    , .live_count (live_count[1])
`endif
  );

  // reference model: one frame = 8 rows taken from the snapshot by shifting
  int          gap_cfg [2] = '{0, GAP_B};
  bit          m_busy  [2] = '{0, 0};
  logic [63:0] m_grid  [2] = '{64'd0, 64'd0};
  int          m_row   [2] = '{0, 0};
  int          m_gap   [2] = '{0, 0};
  bit          m_done  [2] = '{0, 0};
  bit          m_drop  [2] = '{0, 0};
  int          m_acc   [2] = '{0, 0};
  int          m_live  [2] = '{0, 0};

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("row_valid[%0d]", k), 64'(row_valid[k]), 64'(m_busy[k] && m_gap[k] == 0));
      check($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(m_busy[k]));
      check($sformatf("row_idx[%0d]", k), 64'(row_idx[k]), 64'(m_row[k]));
      check($sformatf("row_data[%0d]", k), 64'(row_data[k]), (m_grid[k] >> (8 * m_row[k])) & 64'hFF);
      check($sformatf("frame_done[%0d]", k), 64'(frame_done[k]), 64'(m_done[k]));
      check($sformatf("load_dropped[%0d]", k), 64'(load_dropped[k]), 64'(m_drop[k]));
`ifdef GRID_POPCOUNT_EN
      check($sformatf("live_count[%0d]", k), 64'(live_count[k]), 64'(m_live[k]));
`endif
    end
  endtask

  task automatic model_step();
    logic [7:0] cur;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_busy[k] = 0; m_grid[k] = '0; m_row[k] = 0; m_gap[k] = 0;
        m_done[k] = 0; m_drop[k] = 0; m_acc[k] = 0; m_live[k] = 0;
      end else begin
        m_drop[k] = grid_load && m_busy[k];
        m_done[k] = 0;
        if (!m_busy[k]) begin
          if (grid_load) begin
            m_grid[k] = grid_in; m_row[k] = 0; m_busy[k] = 1; m_acc[k] = 0;
          end
        end else if (m_gap[k] > 0) begin
          m_gap[k]--;
        end else if (row_ready) begin
          cur = 8'((m_grid[k] >> (8 * m_row[k])) & 64'hFF);
          m_acc[k] += $countones(cur);
          if (m_row[k] == 7) begin
            m_busy[k] = 0; m_done[k] = 1; m_live[k] = m_acc[k];
          end else begin
            m_row[k]++; m_gap[k] = gap_cfg[k];
          end
        end
      end
    end
  endtask

  // driver: check what the last edge produced, then apply inputs for the next edge
  task automatic tick(input logic rst, input logic ld, input logic rdy, input logic [63:0] g);
    @(negedge clk);
    check_outputs();
    reset = rst; grid_load = ld; row_ready = rdy; grid_in = g;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1, 64'd0);
  endtask

  localparam logic [63:0] G_BASIC = 64'h0412_6424_0034_3C28;
  bit bp_pat [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    // reset
    tick(1'b0, 1'b0, 1'b0, 64'd0);
    tick(1'b0, 1'b0, 1'b0, 64'd0);

    // basic frame; grid_in cleared right after load (snapshot isolation)
    tick(1'b1, 1'b1, 1'b1, G_BASIC);
    idle(26);
`ifdef GRID_POPCOUNT_EN
    check("basic_live0", 64'(live_count[0]), 64'd17);
    check("basic_live1", 64'(live_count[1]), 64'd17);
`endif

    // backpressure on row 2
    tick(1'b1, 1'b1, 1'b1, G_BASIC);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, bp_pat[i], 64'hDEAD_BEEF_0000_FFFF);
    idle(24);

    // overlapping loads: during row 4, final handshake, then frame_done cycle
    tick(1'b1, 1'b1, 1'b1, G_BASIC);
    for (int i = 0; i < 8; i++) tick(1'b1, (i == 4 || i == 7), 1'b1, 64'h1111_2222_3333_4444);
    tick(1'b1, 1'b1, 1'b1, 64'h8080_4040_2020_1010);
    idle(26);

    // mid-frame reset while row 5 is presented, then an all-ones frame
    tick(1'b1, 1'b1, 1'b1, G_BASIC);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1, 64'd0);
    tick(1'b0, 1'b0, 1'b1, 64'd0);
    tick(1'b1, 1'b0, 1'b0, 64'd0);
    tick(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(26);
`ifdef GRID_POPCOUNT_EN
    check("ones_live0", 64'(live_count[0]), 64'd64);
    check("ones_live1", 64'(live_count[1]), 64'd64);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, {$urandom, $urandom});
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
